// File: rtl/control_multiplicacion_pkg.sv
// Shared definitions for the 4x4 shift-add multiply controller.
//   estado_t        : controller state encoding (also exported on the debug port)
//   ANCHO_DEFECTO   : default operand width
//   ANCHO_PRODUCTO  : matching product width
package paquete_multiplicacion;

    localparam int ANCHO_DEFECTO  = 4;
    localparam int ANCHO_PRODUCTO = 2 * ANCHO_DEFECTO;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CARGA   = 2'd1,
        SUMA    = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

endpackage

// File: rtl/control_multiplicacion_desplazamiento.sv
// Shift-add multiply datapath.
//   reloj, reinicio : clock, async active-high reset
//   cargar          : capture a/b, clear the accumulator
//   paso            : perform one add-and-shift step
//   a, b            : multiplicand, multiplier
//   acumulador      : accumulator value including the current step's addend,
//                     so the controller can register the final sum on the last step
module multiplicador_desplazamiento
    import paquete_multiplicacion::*;
#(
    parameter int ANCHO = ANCHO_DEFECTO
) (
    input  logic               reloj,
    input  logic               reinicio,
    input  logic               cargar,
    input  logic               paso,
    input  logic [ANCHO-1:0]   a,
    input  logic [ANCHO-1:0]   b,
    output logic [2*ANCHO-1:0] acumulador
);

    logic [2*ANCHO-1:0] multiplicando_q;
    logic [ANCHO-1:0]   multiplicador_q;
    logic [2*ANCHO-1:0] acum_q;
    logic [2*ANCHO-1:0] sumando;

    always_comb begin
        sumando    = multiplicador_q[0] ? multiplicando_q : '0;
        acumulador = acum_q + sumando;
    end

    always_ff @(posedge reloj or posedge reinicio) begin
        if (reinicio) begin
            multiplicando_q <= '0;
            multiplicador_q <= '0;
            acum_q          <= '0;
        end else if (cargar) begin
            multiplicando_q <= {{ANCHO{1'b0}}, a};
            multiplicador_q <= b;
            acum_q          <= '0;
        end else if (paso) begin
            acum_q          <= acumulador;
            multiplicando_q <= multiplicando_q << 1;
            multiplicador_q <= multiplicador_q >> 1;
        end
    end

endmodule

// File: rtl/control_multiplicacion.sv
// Sequencer for one unsigned ANCHO x ANCHO multiply per rising edge of iniciar.
//   reloj, reinicio          : clock, async active-high reset
//   operando_a, operando_b   : operands, captured in CARGA
//   iniciar                  : start request (rising edge only)
//   consumidor_listo         : downstream ready
//   producto/producto_valido : registered result and its valid flag
//   ocupado                  : high while computing (CARGA, SUMA)
//   led_operando_a/_b        : high while idle, awaiting operands
//   estado                   : current state, for debug
//
// state   | meaning
// --------+-------------------------------------------------
// REPOSO  | idle, waiting for a rising edge on iniciar
// CARGA   | capture operands, clear accumulator and counter
// SUMA    | ANCHO add-and-shift steps; last one loads producto
// ENTREGA | producto valid, held until consumidor_listo
module control_multiplicacion
    import paquete_multiplicacion::*;
#(
    parameter int ANCHO = ANCHO_DEFECTO
) (
    input  logic               reloj,
    input  logic               reinicio,
    input  logic [ANCHO-1:0]   operando_a,
    input  logic [ANCHO-1:0]   operando_b,
    input  logic               iniciar,
    input  logic               consumidor_listo,
    output logic [2*ANCHO-1:0] producto,
    output logic               producto_valido,
    output logic               ocupado,
    output logic               led_operando_a,
    output logic               led_operando_b,
    output logic [1:0]         estado
);

    localparam int ANCHO_CONT = (ANCHO > 1) ? $clog2(ANCHO) : 1;
    localparam logic [ANCHO_CONT-1:0] ULTIMO_PASO = ANCHO_CONT'(ANCHO - 1);

    estado_t               estado_q, estado_d;
    logic [ANCHO_CONT-1:0] contador_q, contador_d;
    logic [2*ANCHO-1:0]    producto_q, producto_d;
    logic                  iniciar_prev_q;
    logic                  arranque;
    logic                  cargar;
    logic                  paso;
    logic [2*ANCHO-1:0]    acumulador;

    // Edges seen outside REPOSO are dropped, not queued, because
    // iniciar_prev_q tracks iniciar unconditionally.
    assign arranque = iniciar & ~iniciar_prev_q;
    assign cargar   = (estado_q == CARGA);
    assign paso     = (estado_q == SUMA);

    multiplicador_desplazamiento #(.ANCHO(ANCHO)) u_datapath (
        .reloj      (reloj),
        .reinicio   (reinicio),
        .cargar     (cargar),
        .paso       (paso),
        .a          (operando_a),
        .b          (operando_b),
        .acumulador (acumulador)
    );

    always_comb begin
        estado_d   = estado_q;
        contador_d = contador_q;
        producto_d = producto_q;
        case (estado_q)
            REPOSO: begin
                if (arranque) estado_d = CARGA;
            end
            CARGA: begin
                contador_d = '0;
                estado_d   = SUMA;
            end
            SUMA: begin
                contador_d = contador_q + 1'b1;
                if (contador_q == ULTIMO_PASO) begin
                    producto_d = acumulador;
                    estado_d   = ENTREGA;
                end
            end
            ENTREGA: begin
                if (consumidor_listo) estado_d = REPOSO;
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge reloj or posedge reinicio) begin
        if (reinicio) begin
            estado_q       <= REPOSO;
            contador_q     <= '0;
            producto_q     <= '0;
            iniciar_prev_q <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            contador_q     <= contador_d;
            producto_q     <= producto_d;
            iniciar_prev_q <= iniciar;
        end
    end

    assign producto        = producto_q;
    assign producto_valido = (estado_q == ENTREGA);
    assign ocupado         = (estado_q == CARGA) || (estado_q == SUMA);
    assign led_operando_a  = (estado_q == REPOSO);
    assign led_operando_b  = (estado_q == REPOSO);
    assign estado          = estado_q;

endmodule

// File: tb/tb_control_multiplicacion.sv
module tb_control_multiplicacion;

    logic       reloj = 1'b0;
    logic       reinicio;
    logic [3:0] operando_a;
    logic [3:0] operando_b;
    logic       iniciar;
    logic       consumidor_listo;
    logic [7:0] producto;
    logic       producto_valido;
    logic       ocupado;
    logic       led_operando_a;
    logic       led_operando_b;
    logic [1:0] estado;

    control_multiplicacion #(.ANCHO(4)) dut (
        .reloj            (reloj),
        .reinicio         (reinicio),
        .operando_a       (operando_a),
        .operando_b       (operando_b),
        .iniciar          (iniciar),
        .consumidor_listo (consumidor_listo),
        .producto         (producto),
        .producto_valido  (producto_valido),
        .ocupado          (ocupado),
        .led_operando_a   (led_operando_a),
        .led_operando_b   (led_operando_b),
        .estado           (estado)
    );

    always #5 reloj = ~reloj;

    int cyc = 0;
    always @(posedge reloj) cyc <= cyc + 1;

    typedef struct {
        int prod;
        int ciclo;
    } esperado_t;

    esperado_t cola[$];
    int checks   = 0;
    int failures = 0;

    task automatic comparar(input string nombre, input int actual, input int requerido);
        checks++;
        if (actual != requerido) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nombre, actual, requerido, cyc);
        end
    endtask

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    // Reference: a result of a*b appears 6 cycles after the drive point
    // (one edge to sample the start edge, then ANCHO+1 more edges).
    task automatic arrancar(input int a, input int b, input bit espera);
        operando_a = 4'(a);
        operando_b = 4'(b);
        iniciar    = 1'b1;
        if (espera) cola.push_back('{prod: a * b, ciclo: cyc + 6});
        tick();
        iniciar = 1'b0;
    endtask

    task automatic drenar(input bit listo_aleatorio);
        int n = 0;
        while (!(cola.size() == 0 && !producto_valido && estado == 2'd0) && n < 80) begin
            if (listo_aleatorio) consumidor_listo = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        comparar("drain_in_time", int'(n < 80), 1);
    endtask

    task automatic esperar_valido();
        int n = 0;
        while (!producto_valido && n < 30) begin
            tick();
            n++;
        end
        comparar("valid_in_time", int'(producto_valido), 1);
    endtask

    task automatic comprobar_reinicio(input string etiqueta);
        comparar({etiqueta, "_estado"}, int'(estado), 0);
        comparar({etiqueta, "_producto"}, int'(producto), 0);
        comparar({etiqueta, "_valido"}, int'(producto_valido), 0);
        comparar({etiqueta, "_ocupado"}, int'(ocupado), 0);
        comparar({etiqueta, "_led_a"}, int'(led_operando_a), 1);
        comparar({etiqueta, "_led_b"}, int'(led_operando_b), 1);
    endtask

    // Monitor: pops one expectation per new valid window, checks value,
    // latency, stability during stalls, and the drop after the handshake.
    initial begin
        bit        en_txn      = 1'b0;
        bit        espera_baja = 1'b0;
        int        retenido    = 0;
        esperado_t e;
        forever begin
            @(negedge reloj);
            if (reinicio) begin
                en_txn      = 1'b0;
                espera_baja = 1'b0;
            end else if (espera_baja) begin
                comparar("valid_drop_after_ready", int'(producto_valido), 0);
                comparar("estado_after_ready", int'(estado), 0);
                espera_baja = 1'b0;
                en_txn      = 1'b0;
            end else if (producto_valido) begin
                if (!en_txn) begin
                    if (cola.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: got producto %0d with no pending request (cycle %0d)", producto, cyc);
                        retenido = int'(producto);
                    end else begin
                        e = cola.pop_front();
                        comparar("producto", int'(producto), e.prod);
                        comparar("latency_cycle", cyc, e.ciclo);
                        retenido = e.prod;
                    end
                    en_txn = 1'b1;
                end else begin
                    comparar("producto_held", int'(producto), retenido);
                end
                if (consumidor_listo) espera_baja = 1'b1;
            end else begin
                en_txn = 1'b0;
            end
        end
    end

    initial begin
        reinicio         = 1'b1;
        iniciar          = 1'b0;
        operando_a       = '0;
        operando_b       = '0;
        consumidor_listo = 1'b1;
        repeat (3) tick();
        comprobar_reinicio("reset");
        reinicio = 1'b0;
        tick();

        // basic product, ready already high: single-cycle valid pulse
        arrancar(3, 5, 1'b1);
        drenar(1'b0);

        // reset in the middle of SUMA discards the operation
        arrancar(9, 7, 1'b0);
        tick();
        tick();
        comparar("ocupado_mid_suma", int'(ocupado), 1);
        reinicio = 1'b1;
        #1;
        comprobar_reinicio("mid_reset");
        tick();
        reinicio = 1'b0;
        repeat (12) tick();
        comparar("idle_after_reset", int'(estado), 0);

        // long stall: value must hold while valid
        consumidor_listo = 1'b0;
        arrancar(15, 15, 1'b1);
        esperar_valido();
        repeat (10) tick();
        consumidor_listo = 1'b1;
        drenar(1'b0);

        // zero operands keep the same latency
        arrancar(0, 13, 1'b1);
        drenar(1'b0);
        arrancar(11, 0, 1'b1);
        drenar(1'b0);

        // iniciar held high; operands change after capture
        operando_a = 4'd6;
        operando_b = 4'd4;
        iniciar    = 1'b1;
        cola.push_back('{prod: 24, ciclo: cyc + 6});
        repeat (3) tick();
        operando_a = 4'd2;
        operando_b = 4'd2;
        repeat (17) tick();
        iniciar = 1'b0;
        drenar(1'b0);
        repeat (8) tick();

        // second edge during SUMA is ignored; a fresh edge afterwards works
        arrancar(7, 9, 1'b1);
        tick();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        drenar(1'b0);
        repeat (8) tick();
        arrancar(12, 10, 1'b1);
        drenar(1'b0);

        // edge arriving on the same cycle ENTREGA exits is lost
        consumidor_listo = 1'b0;
        arrancar(5, 5, 1'b1);
        esperar_valido();
        consumidor_listo = 1'b1;
        iniciar          = 1'b1;
        tick();
        iniciar = 1'b0;
        drenar(1'b0);
        repeat (10) tick();
        comparar("idle_after_lost_edge", int'(estado), 0);

        // random operands with random backpressure
        for (int i = 0; i < 25; i++) begin
            arrancar(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
            drenar(1'b1);
        end
        consumidor_listo = 1'b1;
        repeat (4) tick();

        comparar("queue_empty", cola.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_multiplicacion.md
Name: control_multiplicacion

Overview:
- Controller that sequences one 4x4 unsigned multiply per user request.
- Detects the rising edge of the start request and captures both operands.
- Drives an ANCHO-step shift-add datapath, then holds the product under a valid/ready handshake until the display/output stage takes it.
- Sits between the operand-reading subsystem and the result display.

Parameters:
- ANCHO, 4, operand width in bits; product width is 2*ANCHO.

Ports:
- reloj  input  1  system clock, rising edge.
- reinicio  input  1  asynchronous, active-high reset.
- operando_a  input  ANCHO  multiplicand, synchronous to reloj.
- operando_b  input  ANCHO  multiplier, synchronous to reloj.
- iniciar  input  1  start request, level, synchronous to reloj; acts on its rising edge only.
- consumidor_listo  input  1  downstream ready.
- producto  output  2*ANCHO  registered result.
- producto_valido  output  1  result valid.
- ocupado  output  1  high in CARGA and SUMA.
- led_operando_a  output  1  high in REPOSO (awaiting operand A).
- led_operando_b  output  1  high in REPOSO (awaiting operand B).
- estado  output  2  current state encoding, for debug.

Behaviour:
- Reset (async, active-high) values:
  - state = REPOSO; contador = 0; iniciar_prev = 0.
  - producto = 0; producto_valido = 0; ocupado = 0.
  - led_operando_a = led_operando_b = 1; estado = 2'd0.
- Start detect: arranque = iniciar & ~iniciar_prev. iniciar_prev is registered every cycle in every state.
- States: REPOSO=0, CARGA=1, SUMA=2, ENTREGA=3.
  - REPOSO -> CARGA on arranque; otherwise stay.
  - CARGA (1 cycle): latch operando_a/operando_b into internal registers; clear accumulator; contador = 0; -> SUMA.
  - SUMA (ANCHO cycles): each cycle, if LSB of the multiplier register is 1, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; contador++. When contador == ANCHO-1, register the final sum into producto and -> ENTREGA.
  - ENTREGA: producto_valido = 1; producto held stable. On consumidor_listo = 1 -> REPOSO, and producto_valido drops the next cycle.
- Latency: edge e0 samples arranque. producto_valido is high after edge e0+ANCHO+1 (5 edges for ANCHO=4). Throughput is at most one product per ANCHO+3 cycles.
- Width rules:
  - Unsigned arithmetic only.
  - Accumulator and shifted multiplicand are 2*ANCHO bits wide; no overflow is possible (15*15 = 225 fits in 8 bits).
- Boundaries:
  - iniciar held high: exactly one operation; a new one needs a low-then-high transition.
  - arranque outside REPOSO (CARGA, SUMA, ENTREGA): ignored, not queued.
  - Operand inputs changing after CARGA: no effect on the result.
  - consumidor_listo already high on ENTREGA entry: one-cycle valid pulse, then REPOSO.
  - arranque in the same cycle ENTREGA exits: ignored. Since iniciar_prev still updates, that edge is lost.
  - Zero operand(s): producto = 0, same latency (no early exit).
  - Reset mid-operation: immediate return to reset values; partial result discarded.
  - producto retains the last value in REPOSO until the next SUMA completes; consumers rely on producto_valido only.

Decomposition:
- Package paquete_multiplicacion:
  - estado_t enum {REPOSO, CARGA, SUMA, ENTREGA} (2-bit).
  - ANCHO_DEFECTO = 4.
  - Width helper constant ANCHO_PRODUCTO = 2*ANCHO_DEFECTO.
- Sub-module multiplicador_desplazamiento:
  - Contains the multiplicand/multiplier shift registers and the accumulator.
  - Inputs: cargar, paso, a, b. Output: acumulador.
  - control_multiplicacion keeps the FSM, counter, edge detect, handshake and output register.

Test Plan:
- Reset asserted mid-SUMA with A=9, B=7 -> next cycle estado=0, producto=0, producto_valido=0, leds=1, no valid afterwards.
- A=3, B=5, one-cycle iniciar pulse, consumidor_listo=1 -> producto_valido high exactly 5 edges after the detect edge, producto=15, one-cycle pulse, then REPOSO.
- A=15, B=15, consumidor_listo=0 for 10 cycles then 1 -> producto=225 held stable with producto_valido=1 for the whole stall, then deasserted one cycle after ready.
- A=0, B=13 and A=11, B=0 -> producto=0 each time with identical latency.
- iniciar held high 20 cycles, operands changed to A=2, B=2 during SUMA (captured A=6, B=4) -> exactly one result, producto=24.
- Second iniciar edge during SUMA, then a fresh edge after return to REPOSO with A=12, B=10 -> first edge ignored, single extra result 120.
